// File: rtl/vtx_pkg.sv
// Shared constants, TX FSM state encoding and per-bank tag type for the
// video line TX scheduler.
package vtx_pkg;

    localparam int LINE_PIXELS_DEF = 480;
    localparam int FRAME_LINES_DEF = 360;
    localparam int NUM_BANKS_DEF   = 2;
    localparam int FRAME_W_DEF     = 8;

    // Tag fields are sized for the widest supported line/frame counters;
    // the top module zero-extends into them and slices back out.
    localparam int TAG_W = 16;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] line;
        logic [TAG_W-1:0] frame;
    } bank_tag_t;

endpackage

// File: rtl/vtx_bank_tracker.sv
// Per-bank full flags and line/frame tags for the line buffer. The write side
// sets a bank when a line completes; the TX side clears it once sent.
module vtx_bank_tracker
    import vtx_pkg::*;
#(
    parameter int NUM_BANKS = NUM_BANKS_DEF,
    localparam int BANK_W   = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [BANK_W-1:0]    set_bank,
    input  bank_tag_t            set_tag,
    input  logic                 clr_en,
    input  logic [BANK_W-1:0]    clr_bank,
    input  logic [BANK_W-1:0]    rd_bank,
    output logic [NUM_BANKS-1:0] full,
    output bank_tag_t            rd_tag
);

    bank_tag_t tags [NUM_BANKS];

    // Set and clear target different banks in practice (a bank is only
    // filled while empty and only freed while full), so both may fire at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                tags[i] <= '0;
            end
        end else begin
            if (clr_en) begin
                full[clr_bank] <= 1'b0;
            end
            if (set_en) begin
                full[set_bank] <= 1'b1;
                tags[set_bank] <= set_tag;
            end
        end
    end

    assign rd_tag = tags[rd_bank];

endmodule

// File: rtl/video_line_tx_scheduler.sv
// Ping-pong line buffer write addressing plus one TX request per completed line.
// Optional macro VTX_DROP_COUNT_EN adds a saturating dropped-line counter o_DropCnt.
module video_line_tx_scheduler
    import vtx_pkg::*;
#(
    parameter int LINE_PIXELS = LINE_PIXELS_DEF,
    parameter int FRAME_LINES = FRAME_LINES_DEF,
    parameter int NUM_BANKS   = NUM_BANKS_DEF,
    parameter int FRAME_W     = FRAME_W_DEF
) (
    input  logic                                   i_Clk,
    input  logic                                   rstb,
    input  logic                                   i_Vsync,
    input  logic                                   i_PixEn,
    output logic                                   o_WrEn,
    output logic [$clog2(NUM_BANKS*LINE_PIXELS)-1:0] o_WrAddr,
    output logic                                   o_TxReq,
    input  logic                                   i_TxAck,
    input  logic                                   i_TxDone,
    output logic [$clog2(NUM_BANKS)-1:0]           o_TxBank,
    output logic [$clog2(FRAME_LINES)-1:0]         o_TxLine,
    output logic [FRAME_W-1:0]                     o_TxFrame,
    output logic [1:0]                             o_TxState,
`ifdef VTX_DROP_COUNT_EN
    output logic [15:0]                            o_DropCnt,
`endif
    output logic                                   o_Overflow
);

    localparam int ADDR_W = $clog2(NUM_BANKS*LINE_PIXELS);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int COL_W  = $clog2(LINE_PIXELS);
    localparam int LINE_W = $clog2(FRAME_LINES);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_PIXELS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);

    logic                 vsync_q;
    logic [COL_W-1:0]     col;
    logic [LINE_W-1:0]    line;
    logic [FRAME_W-1:0]   frame;
    logic [BANK_W-1:0]    wr_bank;
    logic [BANK_W-1:0]    rd_bank;
    logic                 line_acc_q;
    logic                 overflow;
    tx_state_t            tx_state;

    logic [NUM_BANKS-1:0] bank_full;
    bank_tag_t            set_tag;
    bank_tag_t            rd_tag;
    logic                 unused_tag;

    logic vsync_rise;
    logic line_start;
    logic accept;
    logic last_pix;
    logic set_en;
    logic clr_en;
    logic drop_start;

    assign vsync_rise = i_Vsync & ~vsync_q;
    assign line_start = (col == '0);
    // Accept/drop is decided on the first pixel of a line and held for the rest.
    assign accept     = line_start ? ~bank_full[wr_bank] : line_acc_q;
    assign last_pix   = i_PixEn & (col == COL_LAST) & ~vsync_rise;
    assign set_en     = last_pix & accept;
    assign drop_start = i_PixEn & line_start & bank_full[wr_bank] & ~vsync_rise;
    assign clr_en     = (tx_state == TX_BUSY) & i_TxDone;

    assign o_WrEn     = i_PixEn & accept;
    assign o_WrAddr   = ADDR_W'(wr_bank) * ADDR_W'(LINE_PIXELS) + ADDR_W'(col);
    assign o_Overflow = overflow;
    assign o_TxState  = tx_state;

    assign set_tag    = '{line: TAG_W'(line), frame: TAG_W'(frame)};
    assign unused_tag = ^rd_tag;

    vtx_bank_tracker #(
        .NUM_BANKS (NUM_BANKS)
    ) u_bank_tracker (
        .clk      (i_Clk),
        .rst_n    (rstb),
        .set_en   (set_en),
        .set_bank (wr_bank),
        .set_tag  (set_tag),
        .clr_en   (clr_en),
        .clr_bank (rd_bank),
        .rd_bank  (rd_bank),
        .full     (bank_full),
        .rd_tag   (rd_tag)
    );

    // Write side: column/line/frame counters and bank selection. A vsync edge
    // abandons any partial line; its bank was never marked full.
    always_ff @(posedge i_Clk or negedge rstb) begin
        if (!rstb) begin
            vsync_q    <= 1'b0;
            col        <= '0;
            line       <= '0;
            frame      <= '0;
            wr_bank    <= '0;
            line_acc_q <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            vsync_q <= i_Vsync;
            if (vsync_rise) begin
                col   <= '0;
                line  <= '0;
                frame <= frame + 1'b1;
            end else if (i_PixEn) begin
                if (line_start) begin
                    line_acc_q <= ~bank_full[wr_bank];
                end
                if (col == COL_LAST) begin
                    col  <= '0;
                    line <= (line == LINE_LAST) ? '0 : line + 1'b1;
                    if (accept) begin
                        wr_bank <= wr_bank + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (drop_start) begin
                overflow <= 1'b1;
            end
        end
    end

    // Request handshake: o_TxReq rises with the bank tags and holds them stable
    // until the cycle i_TxAck is sampled high; i_TxDone then frees the bank.
    always_ff @(posedge i_Clk or negedge rstb) begin
        if (!rstb) begin
            tx_state  <= TX_IDLE;
            rd_bank   <= '0;
            o_TxReq   <= 1'b0;
            o_TxBank  <= '0;
            o_TxLine  <= '0;
            o_TxFrame <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (bank_full[rd_bank]) begin
                        tx_state  <= TX_REQ;
                        o_TxReq   <= 1'b1;
                        o_TxBank  <= rd_bank;
                        o_TxLine  <= rd_tag.line[LINE_W-1:0];
                        o_TxFrame <= rd_tag.frame[FRAME_W-1:0];
                    end
                end
                TX_REQ: begin
                    if (i_TxAck) begin
                        tx_state <= TX_BUSY;
                        o_TxReq  <= 1'b0;
                    end
                end
                TX_BUSY: begin
                    if (i_TxDone) begin
                        tx_state <= TX_IDLE;
                        rd_bank  <= rd_bank + 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    o_TxReq  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VTX_DROP_COUNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge i_Clk or negedge rstb) begin
        if (!rstb) begin
            drop_cnt <= '0;
        end else if (drop_start && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign o_DropCnt = drop_cnt;
`endif

endmodule

// File: tb/tb_video_line_tx_scheduler.sv
// Directed bench for video_line_tx_scheduler: a fill-order queue model checked
// every cycle, plus literal checks at the points of interest.
module tb_video_line_tx_scheduler;

    localparam int LP = 480;
    localparam int FL = 360;
    localparam int NB = 2;
    localparam int FW = 8;
    localparam int AW = $clog2(NB*LP);
    localparam int BW = $clog2(NB);
    localparam int LW = $clog2(FL);

    logic          i_Clk = 1'b0;
    logic          rstb;
    logic          i_Vsync;
    logic          i_PixEn;
    logic          i_TxAck;
    logic          i_TxDone;
    logic          o_WrEn;
    logic [AW-1:0] o_WrAddr;
    logic          o_TxReq;
    logic [BW-1:0] o_TxBank;
    logic [LW-1:0] o_TxLine;
    logic [FW-1:0] o_TxFrame;
    logic [1:0]    o_TxState;
    logic          o_Overflow;
`ifdef VTX_DROP_COUNT_EN
    logic [15:0]   o_DropCnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    video_line_tx_scheduler #(
        .LINE_PIXELS (LP),
        .FRAME_LINES (FL),
        .NUM_BANKS   (NB),
        .FRAME_W     (FW)
    ) dut (
        .i_Clk      (i_Clk),
        .rstb       (rstb),
        .i_Vsync    (i_Vsync),
        .i_PixEn    (i_PixEn),
        .o_WrEn     (o_WrEn),
        .o_WrAddr   (o_WrAddr),
        .o_TxReq    (o_TxReq),
        .i_TxAck    (i_TxAck),
        .i_TxDone   (i_TxDone),
        .o_TxBank   (o_TxBank),
        .o_TxLine   (o_TxLine),
        .o_TxFrame  (o_TxFrame),
        .o_TxState  (o_TxState),
`ifdef VTX_DROP_COUNT_EN
        .o_DropCnt  (o_DropCnt),
`endif
        .o_Overflow (o_Overflow)
    );

    // ---------------- clock / reset ----------------
    always #5 i_Clk = ~i_Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- model ----------------
    typedef struct {
        int bank;
        int line;
        int frame;
        int fill_cyc;
    } ent_t;
    typedef enum {P_IDLE, P_REQ, P_BUSY} phase_t;

    ent_t   exp_q[$];   // completed lines awaiting transmission, in fill order
    phase_t m_phase;
    int     m_col, m_line, m_frame, m_wr, m_drop, m_cyc;
    bit     m_acc, m_ovf, m_vs_q;
    bit     m_full[NB];
    int     e_bank, e_line, e_frame;

    task automatic reset_model();
        m_col = 0; m_line = 0; m_frame = 0; m_wr = 0; m_drop = 0; m_cyc = 0;
        m_acc = 0; m_ovf = 0; m_vs_q = 0;
        for (int i = 0; i < NB; i++) m_full[i] = 0;
        exp_q.delete();
        m_phase = P_IDLE;
        e_bank = 0; e_line = 0; e_frame = 0;
    endtask

    // ---------------- scoreboard / compare ----------------
    initial begin
        forever begin
            @(negedge i_Clk);
            if (rstb) begin : cmp
                bit ew;
                bit rise;
                int ea;
                ew = i_PixEn && ((m_col == 0) ? !m_full[m_wr] : m_acc);
                ea = m_wr * LP + m_col;
                check("wr_en", o_WrEn, ew);
                if (ew) check("wr_addr", o_WrAddr, ea);
                check("tx_req", o_TxReq, m_phase == P_REQ);
                if (m_phase == P_REQ) begin
                    check("tx_bank", o_TxBank, e_bank);
                    check("tx_line", o_TxLine, e_line);
                    check("tx_frame", o_TxFrame, e_frame);
                end
                check("overflow", o_Overflow, m_ovf);
`ifdef VTX_DROP_COUNT_EN
                check("drop_cnt", o_DropCnt, m_drop);
`endif
                rise   = i_Vsync && !m_vs_q;
                m_vs_q = i_Vsync;
                if (rise) begin
                    m_col = 0;
                    m_line = 0;
                    m_frame = (m_frame + 1) % (1 << FW);
                end else if (i_PixEn) begin
                    if (m_col == 0) begin
                        m_acc = !m_full[m_wr];
                        if (!m_acc) begin
                            m_ovf = 1;
                            if (m_drop < 65535) m_drop++;
                        end
                    end
                    if (m_col == LP - 1) begin
                        if (m_acc) begin
                            m_full[m_wr] = 1;
                            exp_q.push_back('{m_wr, m_line, m_frame, m_cyc});
                            m_wr = (m_wr + 1) % NB;
                        end
                        m_col = 0;
                        m_line = (m_line + 1) % FL;
                    end else begin
                        m_col++;
                    end
                end
                case (m_phase)
                    P_IDLE: if (exp_q.size() > 0 && exp_q[0].fill_cyc < m_cyc) begin
                        m_phase = P_REQ;
                        e_bank  = exp_q[0].bank;
                        e_line  = exp_q[0].line;
                        e_frame = exp_q[0].frame;
                    end
                    P_REQ: if (i_TxAck) m_phase = P_BUSY;
                    P_BUSY: if (i_TxDone) begin
                        m_full[exp_q[0].bank] = 0;
                        void'(exp_q.pop_front());
                        m_phase = P_IDLE;
                    end
                    default: m_phase = P_IDLE;
                endcase
                m_cyc++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_pixels(input int n, input bit exp_en, input int first, input int last);
        for (int i = 0; i < n; i++) begin
            i_PixEn = 1'b1;
            #1;
            if (i == 0) begin
                check("line_first_en", o_WrEn, exp_en);
                if (exp_en) check("line_first_addr", o_WrAddr, first);
            end
            if (i == n - 1) begin
                check("line_last_en", o_WrEn, exp_en);
                if (exp_en) check("line_last_addr", o_WrAddr, last);
            end
            @(posedge i_Clk);
            #1;
        end
        i_PixEn = 1'b0;
    endtask

    task automatic vsync_pulse();
        i_Vsync = 1'b1;
        step();
        i_Vsync = 1'b0;
        step();
    endtask

    task automatic tx_ack_done();
        int n;
        n = 0;
        while (!o_TxReq && n < 20) begin
            step();
            n++;
        end
        check("req_wait", o_TxReq, 1);
        i_TxAck = 1'b1;
        step();
        i_TxAck = 1'b0;
        check("req_low_after_ack", o_TxReq, 0);
        idle(2);
        i_TxDone = 1'b1;
        step();
        i_TxDone = 1'b0;
    endtask

    task automatic check_req(input string name, input int bank, input int line, input int frame);
        check({name, "_req"}, o_TxReq, 1);
        check({name, "_bank"}, o_TxBank, bank);
        check({name, "_line"}, o_TxLine, line);
        check({name, "_frame"}, o_TxFrame, frame);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rstb = 1'b0; i_Vsync = 1'b0; i_PixEn = 1'b0; i_TxAck = 1'b0; i_TxDone = 1'b0;
        reset_model();
        idle(3);
        check("rst_req", o_TxReq, 0);
        check("rst_wren", o_WrEn, 0);
        check("rst_addr", o_WrAddr, 0);
        check("rst_ovf", o_Overflow, 0);
        check("rst_frame", o_TxFrame, 0);
        rstb = 1'b1;
        step();

        // single line: request one cycle after the cycle following the last pixel
        send_pixels(LP, 1, 0, 479);
        check("t1_req_not_yet", o_TxReq, 0);
        step();
        check_req("t1", 0, 0, 0);

        // second line while TX stalls
        send_pixels(LP, 1, 480, 959);
        check_req("t2_stable", 0, 0, 0);

        // third line with both banks full is dropped
        send_pixels(LP, 0, 0, 0);
        check("t3_ovf", o_Overflow, 1);
`ifdef VTX_DROP_COUNT_EN
        check("t3_dropcnt", o_DropCnt, 1);
`endif
        tx_ack_done();
        check("t3_idle_gap", o_TxReq, 0);
        step();
        check_req("t3_bank1", 1, 1, 0);
        send_pixels(LP, 1, 0, 479);
        tx_ack_done();
        step();
        check_req("t3_line3", 0, 3, 0);
        tx_ack_done();

        // line 4 completes, then vsync after 200 pixels of line 5
        send_pixels(LP, 1, 480, 959);
        step();
        check_req("t4_line4", 1, 4, 0);
        tx_ack_done();
        send_pixels(200, 1, 0, 199);
        vsync_pulse();
        idle(5);
        check("t4_no_partial_req", o_TxReq, 0);
        send_pixels(LP, 1, 0, 479);
        step();
        check_req("t4_new_frame", 0, 0, 1);
        tx_ack_done();

        // frame id wraps after 256 vsync edges in total
        for (int i = 0; i < 255; i++) vsync_pulse();
        send_pixels(LP, 1, 480, 959);
        step();
        check_req("t5_wrap", 1, 0, 0);

        // asynchronous reset while BUSY
        i_TxAck = 1'b1;
        step();
        i_TxAck = 1'b0;
        idle(2);
        #2;
        rstb = 1'b0;
        #1;
        check("t6_req", o_TxReq, 0);
        check("t6_bank", o_TxBank, 0);
        check("t6_line", o_TxLine, 0);
        check("t6_frame", o_TxFrame, 0);
        check("t6_ovf", o_Overflow, 0);
        check("t6_wren", o_WrEn, 0);
        check("t6_addr", o_WrAddr, 0);
`ifdef VTX_DROP_COUNT_EN
        check("t6_dropcnt", o_DropCnt, 0);
`endif
        reset_model();
        @(posedge i_Clk);
        #1;
        rstb = 1'b1;
        step();
        send_pixels(LP, 1, 0, 479);
        check("t6_req_not_yet", o_TxReq, 0);
        step();
        check_req("t6_after", 0, 0, 0);

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
